akaur014_simple_circuit: RTL and testbench
==========================================

Name: akaur014_simple_circuit

Overview:
- TinyTapeout user tile holding an 8-bit accumulator driven by a small registered ALU.
- Each enabled clock applies one opcode to the accumulator, using ui_in as the operand.
- The accumulator is driven on uo_out; status flags are driven on the upper bidirectional pins.
- Sits directly under the TinyTapeout harness; no other logic in the tile.

Parameters:
- none. The data width is fixed at 8 bits by the tile interface.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset. One clock; reset is synchronous and active-high: reset is asserted when rst_n = 1 and sampled on the rising edge of clk.
- ena  input  1  tile select. When 0, all state holds.
- ui_in  input  8  operand B (data, or shift amount in bits [2:0]).
- uio_in  input  8  control inputs:
  - [2:0] opcode.
  - [3] exec strobe.
  - [7:4] ignored.
- uo_out  output  8  accumulator value (registered).
- uio_out  output  8  status flags:
  - [7] carry.
  - [6] zero.
  - [5] negative.
  - [4:0] driven constant 0.
- uio_oe  output  8  constant 8'hE0 (uio[7:5] are outputs, uio[4:0] are inputs).

Behaviour:
- State: acc[7:0] and carry, both registers.
- Combinational flags:
  - zero = (acc == 0).
  - negative = acc[7].
- Reset: acc = 0 and carry = 0, so uo_out = 8'h00 and uio_out = 8'h40. Reset wins over ena and exec.
- Update condition: acc and carry update only when ena = 1 and uio_in[3] = 1 on a rising edge. Otherwise both hold.
- Latency: the result is visible on uo_out and uio_out immediately after the updating edge (1 cycle).
- Opcodes (B = ui_in, n = ui_in[2:0]):
  - 000 LOAD: acc = B; carry = 0.
  - 001 ADD: {carry, acc} = acc + B (9-bit sum); wraps modulo 256.
  - 010 SUB: acc = acc - B modulo 256; carry = borrow (1 iff B > acc before the update).
  - 011 AND: acc = acc & B; carry = 0.
  - 100 OR: acc = acc | B; carry = 0.
  - 101 XOR: acc = acc ^ B; carry = 0.
  - 110 SHL: acc = acc << n, zero fill. Carry = old acc[8-n] when n != 0; carry = 0 when n = 0 (acc unchanged).
  - 111 ROR: acc rotated right by n; carry = 0.
- Unused inputs: uio_in[7:4] and ui_in[7:3] (for shift opcodes) have no effect.
- uio_oe and uio_out[4:0] are constants, independent of reset.
- Reset asserted mid-sequence: the next edge clears acc and carry regardless of opcode or exec.

Decomposition:
- Shared package akaur014_pkg:
  - opcode enum (OP_LOAD … OP_ROR, 3 bits).
  - UIO_OE_MASK = 8'hE0.
  - flag bit-index constants (CARRY_BIT = 7, ZERO_BIT = 6, NEG_BIT = 5).
- One combinational sub-module, akaur014_alu:
  - inputs: acc, B, opcode.
  - outputs: next acc, next carry.
- The top level holds the registers, enable gating and pin mapping.

Test Plan:
- Reset: rst_n = 1 for 2 edges -> uo_out = 0x00, uio_out = 0x40, uio_oe = 0xE0.
- LOAD then ADD overflow:
  - LOAD 0x5A -> uo_out = 0x5A.
  - ADD 0xC0 -> uo_out = 0x1A, uio_out[7] = 1, uio_out[6] = 0.
- SUB borrow from acc = 0x10:
  - SUB 0x20 -> uo_out = 0xF0, carry = 1, negative = 1.
  - XOR 0xF0 -> uo_out = 0x00, zero = 1, carry = 0.
- Shifts:
  - LOAD 0x81; SHL n = 1 -> uo_out = 0x02, carry = 1.
  - LOAD 0x01; ROR n = 1 -> uo_out = 0x80, negative = 1.
  - SHL n = 0 -> acc unchanged, carry = 0.
- Gating:
  - With acc = 0x33, opcode = ADD, B = 0x01, and ena = 0 or uio_in[3] = 0 for 3 edges -> uo_out stays 0x33.
  - uio_in[7:4] toggled -> no effect.
- Reset mid-operation: exec ADD asserted with rst_n = 1 on the same edge -> uo_out = 0x00, uio_out = 0x40.

Source files
------------

// File: rtl/akaur014_pkg.sv
// Shared definitions for the akaur014 accumulator tile: opcodes, pin masks
// and status-flag bit positions on the bidirectional port.
package akaur014_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_ROR  = 3'b111
  } opcode_t;

  localparam logic [7:0] UIO_OE_MASK = 8'hE0;

  localparam int CARRY_BIT = 7;
  localparam int ZERO_BIT  = 6;
  localparam int NEG_BIT   = 5;

  localparam int EXEC_BIT  = 3;

endpackage

// File: rtl/akaur014_alu.sv
// Combinational ALU: computes the next accumulator and carry from the
// current accumulator, operand B and the opcode.
module akaur014_alu
  import akaur014_pkg::*;
(
  input  logic [7:0] acc,
  input  logic [7:0] operand,
  input  opcode_t    opcode,
  output logic [7:0] acc_next,
  output logic       carry_next
);

  logic [2:0]  shamt;
  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [8:0]  shl_wide;
  logic [15:0] ror_wide;

  assign shamt    = operand[2:0];
  assign sum      = {1'b0, acc} + {1'b0, operand};
  assign diff     = {1'b0, acc} - {1'b0, operand};
  // Bit 8 of the widened shift is the last bit pushed out, i.e. acc[8-n].
  assign shl_wide = {1'b0, acc} << shamt;
  assign ror_wide = {acc, acc} >> shamt;

  always_comb begin
    acc_next   = acc;
    carry_next = 1'b0;
    unique case (opcode)
      OP_LOAD: acc_next = operand;
      OP_ADD: begin
        acc_next   = sum[7:0];
        carry_next = sum[8];
      end
      OP_SUB: begin
        acc_next   = diff[7:0];
        carry_next = diff[8];
      end
      OP_AND: acc_next = acc & operand;
      OP_OR:  acc_next = acc | operand;
      OP_XOR: acc_next = acc ^ operand;
      OP_SHL: begin
        acc_next   = shl_wide[7:0];
        carry_next = shl_wide[8];
      end
      OP_ROR: acc_next = ror_wide[7:0];
      default: begin
        acc_next   = acc;
        carry_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/akaur014_simple_circuit.sv
// TinyTapeout tile: 8-bit accumulator updated by one ALU opcode per enabled,
// strobed clock; accumulator on uo_out, status flags on uio[7:5].
module akaur014_simple_circuit
  import akaur014_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] acc_reg;
  logic       carry_reg;
  logic [7:0] acc_next;
  logic       carry_next;
  logic       update;

  // The reset pin is active-high despite its harness name.
  wire unused_uio_hi = &{1'b0, uio_in[7:4]};

  assign update = ena & uio_in[EXEC_BIT];

  akaur014_alu u_alu (
    .acc        (acc_reg),
    .operand    (ui_in),
    .opcode     (opcode_t'(uio_in[2:0])),
    .acc_next   (acc_next),
    .carry_next (carry_next)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_reg   <= 8'h00;
      carry_reg <= 1'b0;
    end else if (update) begin
      acc_reg   <= acc_next;
      carry_reg <= carry_next;
    end
  end

  always_comb begin
    uio_out            = 8'h00;
    uio_out[CARRY_BIT] = carry_reg;
    uio_out[ZERO_BIT]  = (acc_reg == 8'h00);
    uio_out[NEG_BIT]   = acc_reg[7];
  end

  assign uo_out = acc_reg;
  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_akaur014_simple_circuit.sv
// Self-checking bench for the accumulator tile: directed scenarios followed by
// randomized traffic, all checked against an arithmetic reference model.
module tb_akaur014_simple_circuit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_acc   = 0;
  int m_carry = 0;

  always #5 clk = ~clk;

  akaur014_simple_circuit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_op(input int op, input int b, input int acc, output int carry);
    int n;
    int r;
    n     = b % 8;
    carry = 0;
    r     = acc;
    case (op)
      0: r = b;
      1: begin r = (acc + b) % 256; carry = (acc + b > 255) ? 1 : 0; end
      2: begin r = (acc - b + 256) % 256; carry = (b > acc) ? 1 : 0; end
      3: r = acc & b;
      4: r = acc | b;
      5: r = acc ^ b;
      6: begin
        r = (acc * (1 << n)) % 256;
        carry = (n != 0) ? ((acc >> (8 - n)) % 2) : 0;
      end
      default: r = ((acc >> n) | (acc << (8 - n))) % 256;
    endcase
    return r;
  endfunction

  task automatic cycle(input string tag, input bit r, input bit e, input bit x,
                       input int op, input int b, input int hi);
    int nc;
    int na;
    int exp_uio;
    rst_n  = r;
    ena    = e;
    ui_in  = 8'(b);
    uio_in = {4'(hi), x, 3'(op)};
    @(posedge clk);
    #1;
    if (r) begin
      m_acc   = 0;
      m_carry = 0;
    end else if (e && x) begin
      na      = model_op(op, b, m_acc, nc);
      m_acc   = na;
      m_carry = nc;
    end
    exp_uio = m_carry * 128 + ((m_acc == 0) ? 64 : 0) + ((m_acc >= 128) ? 32 : 0);
    check({tag, ".acc"}, {8'h00, uo_out}, 16'(m_acc));
    check({tag, ".flags"}, {8'h00, uio_out}, 16'(exp_uio));
    check({tag, ".oe"}, {8'h00, uio_oe}, 16'h00E0);
    $display("txn %-10s rst=%0d ena=%0d exec=%0d op=%0d b=%02h -> acc=%02h uio=%02h",
             tag, r, e, x, op, b & 255, uo_out, uio_out);
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    cycle("reset0", 1, 0, 0, 0, 0, 0);
    cycle("reset1", 1, 1, 1, 1, 8'h77, 0);
    check("reset.uo", {8'h00, uo_out}, 16'h0000);
    check("reset.uio", {8'h00, uio_out}, 16'h0040);

    cycle("load5a", 0, 1, 1, 0, 8'h5A, 0);
    check("load5a.uo", {8'h00, uo_out}, 16'h005A);
    cycle("addc0", 0, 1, 1, 1, 8'hC0, 0);
    check("addc0.uo", {8'h00, uo_out}, 16'h001A);
    check("addc0.c", {15'h0, uio_out[7]}, 16'h0001);
    check("addc0.z", {15'h0, uio_out[6]}, 16'h0000);

    cycle("load10", 0, 1, 1, 0, 8'h10, 0);
    cycle("sub20", 0, 1, 1, 2, 8'h20, 0);
    check("sub20.uo", {8'h00, uo_out}, 16'h00F0);
    check("sub20.cn", {14'h0, uio_out[7], uio_out[5]}, 16'h0003);
    cycle("xorf0", 0, 1, 1, 5, 8'hF0, 0);
    check("xorf0.uio", {8'h00, uio_out}, 16'h0040);

    cycle("load81", 0, 1, 1, 0, 8'h81, 0);
    cycle("shl1", 0, 1, 1, 6, 8'hF9, 0);
    check("shl1.uo", {8'h00, uo_out}, 16'h0002);
    check("shl1.c", {15'h0, uio_out[7]}, 16'h0001);
    cycle("load01", 0, 1, 1, 0, 8'h01, 0);
    cycle("ror1", 0, 1, 1, 7, 8'h01, 0);
    check("ror1.uio", {uo_out, uio_out}, 16'h8020);
    cycle("load81b", 0, 1, 1, 0, 8'h81, 0);
    cycle("shl1b", 0, 1, 1, 6, 8'h01, 0);
    cycle("shl0", 0, 1, 1, 6, 8'hF8, 0);
    check("shl0.uo", {8'h00, uo_out}, 16'h0002);
    check("shl0.c", {15'h0, uio_out[7]}, 16'h0000);
    cycle("shl7", 0, 1, 1, 6, 8'h07, 0);

    cycle("load33", 0, 1, 1, 0, 8'h33, 0);
    cycle("gate_ena", 0, 0, 1, 1, 8'h01, 0);
    cycle("gate_exe", 0, 1, 0, 1, 8'h01, 4'hF);
    cycle("gate_both", 0, 0, 0, 1, 8'h01, 4'hA);
    check("gate.uo", {8'h00, uo_out}, 16'h0033);
    cycle("hi_nibble", 0, 1, 1, 1, 8'h01, 4'h9);
    check("hi.uo", {8'h00, uo_out}, 16'h0034);

    cycle("rst_mid", 1, 1, 1, 1, 8'h55, 0);
    check("rst_mid.uo", {uo_out, uio_out}, 16'h0040);

    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 4) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
